// File: rtl/mem_bus_responder.sv
// Responder for the instruction and data request/grant/rvalid buses.
// It owns a word-addressed memory and grants at most one port per cycle.
module mem_bus_responder #(
    parameter int unsigned MEM_SIZE   = 8192,
    parameter logic [31:0] MEM_START  = 32'h0000_0000,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned AW    = $clog2(MEM_SIZE);
    localparam int unsigned WORDS = MEM_SIZE / 4;
    localparam int unsigned IW    = (AW > 2) ? AW - 2 : 1;
    localparam int unsigned CW    = $clog2(STARVE_MAX + 1);

    localparam logic [31:0]   ADDR_MASK  = ~(32'(MEM_SIZE) - 32'd1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [31:0] mem [WORDS];

    logic          instr_in_range;
    logic          data_in_range;
    logic [IW-1:0] instr_idx;
    logic [IW-1:0] data_idx;
    logic          unused_addr_lsbs;

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    logic          data_prio;

    logic        instr_rvalid_q;
    logic [31:0] instr_rdata_q;
    logic        instr_err_q;
    logic        data_rvalid_q;
    logic [31:0] data_rdata_q;
    logic        data_err_q;

    assign instr_in_range = (instr_addr_i & ADDR_MASK) == MEM_START;
    assign data_in_range  = (data_addr_i & ADDR_MASK) == MEM_START;

    generate
        if (AW > 2) begin : g_word_idx
            assign instr_idx = instr_addr_i[AW-1:2];
            assign data_idx  = data_addr_i[AW-1:2];
        end else begin : g_single_word
            assign instr_idx = '0;
            assign data_idx  = '0;
        end
    endgenerate

    // Byte offset within a word never affects the access.
    assign unused_addr_lsbs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    // Instr has priority unless data has been refused STARVE_MAX cycles in a row.
    assign data_prio   = (starve_q == STARVE_LIM);
    assign instr_gnt_o = rst_ni & instr_req_i & ~(data_req_i & data_prio);
    assign data_gnt_o  = rst_ni & data_req_i & ~instr_gnt_o;

    always_comb begin
        starve_d = starve_q;
        if (!data_req_i || data_gnt_o) begin
            starve_d = '0;
        end else if (!data_prio) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q       <= '0;
            instr_rvalid_q <= 1'b0;
            instr_rdata_q  <= '0;
            instr_err_q    <= 1'b0;
            data_rvalid_q  <= 1'b0;
            data_rdata_q   <= '0;
            data_err_q     <= 1'b0;
        end else begin
            starve_q       <= starve_d;
            instr_rvalid_q <= instr_gnt_o;
            data_rvalid_q  <= data_gnt_o;
            if (instr_gnt_o) begin
                instr_rdata_q <= instr_in_range ? mem[instr_idx] : '0;
                instr_err_q   <= ~instr_in_range;
            end
            if (data_gnt_o) begin
                // Reads see the word as it was before this edge's write.
                data_rdata_q <= (data_in_range && !data_we_i) ? mem[data_idx] : '0;
                data_err_q   <= ~data_in_range;
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk_i) begin
        if (data_gnt_o && data_we_i && data_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[data_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign instr_rvalid_o = instr_rvalid_q;
    assign instr_rdata_o  = instr_rdata_q;
    assign instr_err_o    = instr_err_q;
    assign data_rvalid_o  = data_rvalid_q;
    assign data_rdata_o   = data_rdata_q;
    assign data_err_o     = data_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: grant checks inline per task,
// responses checked by a scoreboard fed from a reference memory model.
module tb_mem_bus_responder;

    localparam int unsigned MEM_SIZE   = 8192;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } resp_t;

    resp_t       iq[$];
    resp_t       dq[$];
    logic [31:0] model [MEM_SIZE/4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_responder #(
        .MEM_SIZE   (MEM_SIZE),
        .MEM_START  (32'h0000_0000),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err)
    );

    function automatic bit in_range(input logic [31:0] a);
        return (a & ~(32'(MEM_SIZE) - 32'd1)) == 32'h0;
    endfunction

    // Scoreboard consumer: every rvalid must match the oldest due entry.
    always @(negedge clk) begin
        resp_t r;
        if (instr_rvalid) begin
            checks++;
            if (iq.size() == 0 || iq[0].due != cyc) begin
                failures++;
                $display("FAIL instr_rvalid_unexpected got=1 want=0 cyc=%0d", cyc);
            end else begin
                r = iq.pop_front();
                if (instr_rdata !== r.rdata || instr_err !== r.err) begin
                    failures++;
                    $display("FAIL instr_resp got rdata=%h err=%b want rdata=%h err=%b",
                             instr_rdata, instr_err, r.rdata, r.err);
                end
            end
        end else if (iq.size() != 0 && iq[0].due <= cyc) begin
            checks++;
            failures++;
            $display("FAIL instr_rvalid_missing got=0 want=1 cyc=%0d", cyc);
            void'(iq.pop_front());
        end
        if (data_rvalid) begin
            checks++;
            if (dq.size() == 0 || dq[0].due != cyc) begin
                failures++;
                $display("FAIL data_rvalid_unexpected got=1 want=0 cyc=%0d", cyc);
            end else begin
                r = dq.pop_front();
                if (data_rdata !== r.rdata || data_err !== r.err) begin
                    failures++;
                    $display("FAIL data_resp got rdata=%h err=%b want rdata=%h err=%b",
                             data_rdata, data_err, r.rdata, r.err);
                end
            end
        end else if (dq.size() != 0 && dq[0].due <= cyc) begin
            checks++;
            failures++;
            $display("FAIL data_rvalid_missing got=0 want=1 cyc=%0d", cyc);
            void'(dq.pop_front());
        end
    end

    task automatic set_inputs(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                              input bit dwe, input logic [3:0] dbe,
                              input logic [31:0] daddr, input logic [31:0] dwdata);
        instr_req  = ireq;
        instr_addr = iaddr;
        data_req   = dreq;
        data_we    = dwe;
        data_be    = dbe;
        data_addr  = daddr;
        data_wdata = dwdata;
    endtask

    // Producer: push the expected response for each grant the model predicts.
    task automatic expect_grant(input bit ig, input bit dg);
        resp_t r;
        if (ig) begin
            r.err   = !in_range(instr_addr);
            r.rdata = r.err ? 32'h0 : model[instr_addr[12:2]];
            r.due   = cyc + 1;
            iq.push_back(r);
        end
        if (dg) begin
            r.err   = !in_range(data_addr);
            r.rdata = (r.err || data_we) ? 32'h0 : model[data_addr[12:2]];
            r.due   = cyc + 1;
            dq.push_back(r);
            if (!r.err && data_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (data_be[b]) model[data_addr[12:2]][8*b +: 8] = data_wdata[8*b +: 8];
                end
            end
        end
    endtask

    task automatic idle_cycle();
        set_inputs(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
    endtask

    // Single data-only transaction with inline grant check.
    task automatic data_txn(input string name, input bit we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        set_inputs(0, 32'h0, 1, we, be, addr, wdata);
        @(negedge clk);
        checks++;
        if (data_gnt !== 1'b1 || instr_gnt !== 1'b0) begin
            failures++;
            $display("FAIL %s_gnt got d=%b i=%b want d=1 i=0", name, data_gnt, instr_gnt);
        end
        expect_grant(0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        set_inputs(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (instr_gnt !== 1'b0 || data_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_gnt got i=%b d=%b want 0 0", instr_gnt, data_gnt);
        end
        checks++;
        if ({instr_rvalid, instr_err, data_rvalid, data_err} !== 4'b0 ||
            instr_rdata !== 32'h0 || data_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got iv=%b ie=%b ir=%h dv=%b de=%b dr=%h want all 0",
                     instr_rvalid, instr_err, instr_rdata, data_rvalid, data_err, data_rdata);
        end
        set_inputs(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_preload();
        data_txn("preload32", 1, 4'hF, 32'h80, 32'h1234_5678);
        data_txn("preload0", 1, 4'hF, 32'h0, 32'hCAFE_F00D);
        data_txn("preload84", 1, 4'hF, 32'h84, 32'h0BAD_F00D);
        idle_cycle();
    endtask

    task automatic test_instr_stream();
        set_inputs(1, 32'h80, 0, 0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (instr_gnt !== 1'b1) begin
                failures++;
                $display("FAIL instr_stream_gnt%0d got=%b want=1", i, instr_gnt);
            end
            expect_grant(1, 0);
            @(posedge clk);
            #1;
        end
        // Address bits [1:0] are ignored: 0x87 reads word 33.
        set_inputs(1, 32'h87, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        expect_grant(1, 0);
        @(posedge clk);
        #1;
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_write_read();
        data_txn("wr_full", 1, 4'hF, 32'h100, 32'hDEAD_BEEF);
        data_txn("rd_full", 0, 4'hF, 32'h100, 32'h0);
        idle_cycle();
    endtask

    task automatic test_byte_enable();
        data_txn("wr_be1", 1, 4'b0001, 32'h100, 32'h0000_00AA);
        data_txn("rd_be1", 0, 4'hF, 32'h100, 32'h0);
        data_txn("wr_be0", 1, 4'b0000, 32'h100, 32'h5555_5555);
        data_txn("rd_be0", 0, 4'hF, 32'h100, 32'h0);
        data_txn("wr_be_hi", 1, 4'b1100, 32'h102, 32'h7766_0000);
        data_txn("rd_be_hi", 0, 4'hF, 32'h100, 32'h0);
        idle_cycle();
    endtask

    task automatic test_starvation();
        bit exp_d;
        set_inputs(1, 32'h80, 1, 0, 4'hF, 32'h84, 32'h0);
        for (int i = 0; i < 2 * (STARVE_MAX + 1); i++) begin
            exp_d = ((i % (STARVE_MAX + 1)) == STARVE_MAX);
            @(negedge clk);
            checks++;
            if (data_gnt !== exp_d || instr_gnt !== !exp_d) begin
                failures++;
                $display("FAIL starve_gnt%0d got i=%b d=%b want i=%b d=%b",
                         i, instr_gnt, data_gnt, !exp_d, exp_d);
            end
            expect_grant(!exp_d, exp_d);
            @(posedge clk);
            #1;
        end
        idle_cycle();
    endtask

    task automatic test_out_of_range();
        data_txn("oor_rd", 0, 4'hF, 32'h0000_2000, 32'h0);
        data_txn("oor_wr", 1, 4'hF, 32'h0000_2000, 32'hFFFF_FFFF);
        data_txn("oor_wr_hi", 1, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF);
        data_txn("alias_rd", 0, 4'hF, 32'h0, 32'h0);
        set_inputs(1, 32'h0001_0080, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (instr_gnt !== 1'b1) begin
            failures++;
            $display("FAIL oor_instr_gnt got=%b want=1", instr_gnt);
        end
        expect_grant(1, 0);
        @(posedge clk);
        #1;
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr;
        logic [31:0] wd;
        for (int i = 0; i < 6; i++) begin
            addr = {19'h0, 11'($urandom_range(0, 2047)), 2'b00};
            wd   = $urandom;
            data_txn("b2b_wr", 1, 4'($urandom_range(0, 15)), addr, wd);
            data_txn("b2b_rd", 0, 4'hF, addr, 32'h0);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        set_inputs(0, 32'h0, 1, 0, 4'hF, 32'h100, 32'h0);
        @(negedge clk);
        checks++;
        if (data_gnt !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_gnt got=%b want=1", data_gnt);
        end
        #2;
        rst_ni = 1'b0;
        iq.delete();
        dq.delete();
        @(posedge clk);
        #1;
        checks++;
        if (data_rvalid !== 1'b0 || instr_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_rvalid got d=%b i=%b want 0 0", data_rvalid, instr_rvalid);
        end
        set_inputs(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (data_rvalid !== 1'b0 || instr_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_rvalid%0d got d=%b i=%b want 0 0",
                         i, data_rvalid, instr_rvalid);
            end
        end
        @(posedge clk);
        #1;
        data_txn("post_reset_rd", 0, 4'hF, 32'h100, 32'h0);
        idle_cycle();
    endtask

    initial begin
        set_inputs(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        test_reset();
        test_preload();
        test_reset();
        test_instr_stream();
        test_write_read();
        test_byte_enable();
        test_starvation();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        repeat (3) idle_cycle();
        checks++;
        if (iq.size() != 0 || dq.size() != 0) begin
            failures++;
            $display("FAIL drain got iq=%0d dq=%0d want 0 0", iq.size(), dq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Responder end of the core's instruction and data request/grant/rvalid buses.
- Replaces the single-port RAM plus combinational arbiter with one block.
- Owns a word-addressed memory array and arbitrates the two initiator ports onto it.
- Issues grants, returns read data one cycle after grant, and flags out-of-range accesses on the err lines.

Parameters:
- MEM_SIZE, 8192, memory size in bytes; power of two, at least 4.
- MEM_START, 32'h00000000, base byte address; aligned to MEM_SIZE.
- STARVE_MAX, 4, consecutive cycles a pending data request may be refused before it takes priority; at least 1.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- instr_req_i  input  1  instruction fetch request
- instr_addr_i  input  32  fetch byte address
- instr_gnt_o  output  1  fetch request accepted this cycle
- instr_rvalid_o  output  1  fetch response valid
- instr_rdata_o  output  32  fetch read data
- instr_err_o  output  1  fetch response error (out of range)
- data_req_i  input  1  data request
- data_we_i  input  1  1 = write, 0 = read
- data_be_i  input  4  byte enables
- data_addr_i  input  32  data byte address
- data_wdata_i  input  32  write data
- data_gnt_o  output  1  data request accepted this cycle
- data_rvalid_o  output  1  data response valid
- data_rdata_o  output  32  data read data
- data_err_o  output  1  data response error (out of range)

Behaviour:
- Reset, asynchronous, active-low:
  - All rvalid, err and rdata outputs go to 0; the starvation counter clears.
  - Memory contents are not reset.
  - Grants are combinational and are 0 while rst_ni is low.
- Grant, combinational, at most one port per cycle:
  - If only one port requests, that port is granted.
  - If both request, instr wins, unless starve_cnt equals STARVE_MAX; then data wins.
  - Neither grant asserts when no port requests.
- Starvation counter:
  - Width is clog2(STARVE_MAX+1) bits.
  - Increments, saturating at STARVE_MAX, each cycle data_req_i=1 and data_gnt_o=0.
  - Clears on data grant and when data_req_i=0.
- Address check:
  - in_range = ((addr & ~(MEM_SIZE-1)) == MEM_START).
  - Word index = addr[clog2(MEM_SIZE)-1:2]; addr[1:0] is ignored.
- Granted in-range data write: bytes with be[i]=1 are written at the clock edge ending the grant cycle. be=0000 writes nothing but still completes normally.
- Granted out-of-range access: no array read or write.
- Response timing:
  - Exactly one cycle after grant, the granted port's rvalid is 1 for exactly one cycle.
  - The other port's rvalid is 0 in that cycle.
  - Latency is fixed, so a port never has more than one response outstanding.
- Response contents:
  - Read in range: rdata = array word as it was before any write in the grant cycle, err=0.
  - Write in range: rdata = 0, err=0.
  - Out of range (read or write): rdata = 0, err=1.
  - rdata and err hold their last value while rvalid=0. Benches must check them only with rvalid=1.
- Back-to-back grants: a port may be granted on consecutive cycles, giving consecutive rvalid pulses.
- Initiator obligations:
  - Requests are held until granted; req/addr/wdata changes while ungranted are legal and are re-arbitrated each cycle.
  - The block does not check the initiator side.
- Reset mid-operation: any response pending for the next edge is dropped; no rvalid follows reset release.
- Write then read of the same word on consecutive grants: the read returns the new data.

Test Plan:
- Reset, then hold instr_req=1 with addr 0x80 for 3 cycles -> instr_gnt=1 every cycle; instr_rvalid=1 on cycles 2-4 with array[32].
- Data write 0xDEADBEEF to 0x100 with be=1111, then a read of 0x100 -> second rvalid carries rdata 0xDEADBEEF, err=0.
- Preload 0x100 with 0xDEADBEEF. Write 0x000000AA to 0x100 with be=0001, then read it -> rdata 0xDEADBEAA.
- instr_req and data_req both held high continuously:
  - STARVE_MAX=4 -> instr granted 4 cycles, data granted on the 5th, instr again on the 6th.
  - Counter is 0 after the data grant.
- Data read at 0x00002000 (MEM_SIZE=8192, MEM_START=0) -> data_gnt=1; next cycle data_rvalid=1, data_err=1, rdata=0; the array is unchanged.
- Grant a read, then assert rst_ni=0 before the next edge -> rvalid stays 0; after release, no rvalid until a new grant.
